id_ex_pipe_reg: RTL

ID/EX pipeline register of the five-stage MIPS datapath. Captures decoded operands, register numbers and control from ID and presents them to EX, where the forwarding unit compares ex_rs/ex_rt against the EX/MEM and MEM/WB destinations. Also detects load-use hazards, inserting bubbles and requesting an upstream hold. An optional WB-to-ID bypass covers same-cycle register-file write/read collisions.

---
 rtl/id_ex_pipe_reg.sv | 131 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register of the five-stage MIPS datapath. Captures decoded
// operands, register numbers and control from ID and presents them to EX.
// Detects load-use hazards: it inserts a bubble and raises lu_stall so that
// the PC and IF/ID hold.
//
// Optional feature (compile-time macro ID_EX_WB_BYPASS_EN): a WB-to-ID bypass
// that replaces register-file read data with wb_data on a same-cycle
// write/read collision. When the macro is undefined, the register file must
// provide write-before-read.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               global freeze: all registers hold
//   flush               replace the captured instruction with a bubble
//   id_*                decoded instruction from ID
//   wb_reg_write/rd/data  WB-stage register-file write port (bypass only)
//   ex_*                registered instruction presented to EX
//   lu_stall            combinational load-use hazard flag
//   bubble_cnt          saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_op,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [3:0]        ex_alu_op,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              lu_stall,
    output logic [15:0]       bubble_cnt
);

    logic [DATA_W-1:0] rs_data_nxt;
    logic [DATA_W-1:0] rt_data_nxt;
    logic              load_bubble;

    // Load in EX whose destination is read by the instruction now in ID.
    assign lu_stall = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

    // Flush always wins over a stall; a load-use bubble waits for the stall.
    assign load_bubble = flush | (~stall & lu_stall);

`ifdef ID_EX_WB_BYPASS_EN
    // Same-cycle WB write to a register ID is reading: take the new value.
    assign rs_data_nxt = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs)) ? wb_data : id_rs_data;
    assign rt_data_nxt = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt)) ? wb_data : id_rt_data;
`else
    assign rs_data_nxt = id_rs_data;
    assign rt_data_nxt = id_rt_data;

    // WB port is only consumed by the bypass.
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_reg_write, wb_rd, wb_data};
`endif

    // Pipeline register with rst > flush > stall > load-use bubble > load.
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            // Bubble register numbers are 0 so forwarding never matches one.
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_alu_op     <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            if (rst) begin
                bubble_cnt <= '0;
            end else if (!flush && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'(1);
            end
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_src    <= id_alu_src;
            ex_reg_dst    <= id_reg_dst;
            ex_alu_op     <= id_alu_op;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_rs_data    <= rs_data_nxt;
            ex_rt_data    <= rt_data_nxt;
            ex_imm        <= id_imm;
        end
    end

endmodule
